// File: rtl/parity_stripe_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : parity_stripe_buffer_if
//  Purpose  : PSL buffer-write / buffer-read bus seen by the parity stripe buffer.
//  Revision : 1.0  initial release
// ============================================================================
interface parity_stripe_buffer_if;
    logic         write_valid;
    logic [0:7]   write_tag;
    logic [0:5]   write_address;
    logic [0:511] write_data;
    logic         read_valid;
    logic [0:7]   read_tag;
    logic [0:5]   read_address;
    logic [0:511] read_data;
    logic [0:7]   read_parity;

    modport master (
        output write_valid, write_tag, write_address, write_data,
        output read_valid, read_tag, read_address,
        input  read_data, read_parity
    );

    modport slave (
        input  write_valid, write_tag, write_address, write_data,
        input  read_valid, read_tag, read_address,
        output read_data, read_parity
    );
endinterface
`default_nettype wire

// File: rtl/parity_stripe_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : parity_stripe_buffer
//  Purpose  : XOR-accumulates two 128-byte stripe lines into a parity line and
//             serves it back over the PSL buffer-read interface.
//  Revision : 1.0  initial release
// ============================================================================
module parity_stripe_buffer #(
    parameter logic [7:0] STRIPE1_TAG = 8'h01,
    parameter logic [7:0] STRIPE2_TAG = 8'h02,
    parameter logic [7:0] PARITY_TAG  = 8'h03
) (
    input  wire logic                    clock,
    input  wire logic                    reset_n,
    input  wire logic                    clear,
    parity_stripe_buffer_if.slave        bus,
    output logic                         parity_ready,
    output logic                         error,
    output logic [0:31]                  lines_done
);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_READY   = 2'd1,
        ST_DRAINED = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [0:511]  r_acc [0:1];
    logic [0:3]    r_wmask;          // {s1h0, s1h1, s2h0, s2h1}
    logic [0:1]    r_rmask;          // {h0, h1}
    logic [0:3]    w_wmask_next;
    logic [0:1]    w_rmask_next;
    logic [0:511]  r_read_data;
    logic          r_error;
    logic [0:31]   r_lines_done;

    logic          w_wr_is_s1;
    logic          w_wr_is_s2;
    logic          w_wr_stripe;
    logic [1:0]    w_wr_idx;
    logic          w_wr_half;
    logic          w_wr_accept;
    logic          w_wr_err;
    logic          w_rd_parity;
    logic          w_rd_serve;
    logic          w_rd_err;
    logic          w_rd_half;
    logic          w_line_done;
    logic [0:7]    w_read_parity;
    logic          w_unused_addr;

    assign w_wr_is_s1  = (bus.write_tag == STRIPE1_TAG);
    assign w_wr_is_s2  = (bus.write_tag == STRIPE2_TAG);
    assign w_wr_stripe = bus.write_valid && (w_wr_is_s1 || w_wr_is_s2);
    assign w_wr_half   = bus.write_address[5];
    assign w_wr_idx    = {w_wr_is_s2, w_wr_half};
    assign w_wr_accept = w_wr_stripe && (r_state == ST_COLLECT) && !r_wmask[w_wr_idx];
    assign w_wr_err    = w_wr_stripe && !w_wr_accept;

    assign w_rd_parity = bus.read_valid && (bus.read_tag == PARITY_TAG);
    assign w_rd_serve  = w_rd_parity && (r_state != ST_COLLECT);
    assign w_rd_err    = w_rd_parity && (r_state == ST_COLLECT);
    assign w_rd_half   = bus.read_address[5];

    // Only bit 5 of each half-line index selects storage.
    assign w_unused_addr = ^{bus.write_address[0:4], bus.read_address[0:4]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_wmask_next = r_wmask;
        w_rmask_next = r_rmask;
        w_line_done  = 1'b0;
        if (w_wr_accept) begin
            w_wmask_next[w_wr_idx] = 1'b1;
        end
        if (w_rd_serve && (r_state == ST_READY)) begin
            w_rmask_next[w_rd_half] = 1'b1;
        end
        case (r_state)
            ST_COLLECT: begin
                if (w_wmask_next == 4'b1111) begin
                    w_state_next = ST_READY;
                end
            end
            ST_READY: begin
                if (w_rmask_next == 2'b11) begin
                    w_state_next = ST_DRAINED;
                    w_line_done  = 1'b1;
                end
            end
            ST_DRAINED: begin
                w_state_next = ST_DRAINED;
            end
            default: begin
                w_state_next = ST_COLLECT;
            end
        endcase
        // clear outranks any completion landing in the same cycle
        if (clear) begin
            w_state_next = ST_COLLECT;
            w_line_done  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_acc[0]     <= '0;
            r_acc[1]     <= '0;
            r_wmask      <= '0;
            r_rmask      <= '0;
            r_read_data  <= '0;
            r_error      <= 1'b0;
            r_lines_done <= '0;
        end else begin
            // read data is taken from pre-clear contents, even alongside clear
            if (w_rd_serve) begin
                r_read_data <= r_acc[w_rd_half];
            end else if (bus.read_valid) begin
                r_read_data <= '0;
            end
            if (clear) begin
                r_acc[0] <= '0;
                r_acc[1] <= '0;
                r_wmask  <= '0;
                r_rmask  <= '0;
                r_error  <= 1'b0;
            end else begin
                if (w_wr_accept) begin
                    r_acc[w_wr_half] <= r_acc[w_wr_half] ^ bus.write_data;
                end
                r_wmask <= w_wmask_next;
                r_rmask <= w_rmask_next;
                if (w_wr_err || w_rd_err) begin
                    r_error <= 1'b1;
                end
            end
            if (w_line_done) begin
                r_lines_done <= r_lines_done + 32'd1;
            end
        end
    end

    // Odd parity per doubleword: an all-zero doubleword reports 1.
    generate
        for (genvar i = 0; i < 8; i++) begin : g_dw_parity
            assign w_read_parity[i] = ~^r_read_data[64*i +: 64];
        end
    endgenerate

    assign bus.read_data   = r_read_data;
    assign bus.read_parity = w_read_parity;
    assign parity_ready    = (r_state == ST_READY) || (r_state == ST_DRAINED);
    assign error           = r_error;
    assign lines_done      = r_lines_done;

endmodule
`default_nettype wire
